// File: rtl/ram_responder.sv
// ram_responder: accepts 32-bit word read/write commands and serves them
// from an external 16-bit asynchronous SRAM as two little-endian halfword beats.
// Each beat lasts WAIT_CYCLES+1 clocks. Writes insert a one-cycle gap with
// we_n high between the two halfwords.
// Optional feature: define RAM_RESPONDER_WRITE_EN to build the write path.
// Without it, ram_write is ignored, and we_n and dq_oe are tied inactive.
module ram_responder #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_read,
  input  logic        ram_write,
  input  logic [15:0] ram_addr,
  input  logic [31:0] ram_wdata,
  output logic        ram_cack,
  output logic        ram_busy,
  output logic        ram_data_ready,
  output logic [31:0] ram_data,
  output logic [16:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI
`ifdef RAM_RESPONDER_WRITE_EN
    ,
    WR_LO,
    WR_GAP,
    WR_HI
`endif
  } state_t;

  localparam logic [3:0] BEAT_LAST = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] addr_q;
  logic [15:0] rd_lo;
  logic        beat_done;

  assign beat_done = (cnt == BEAT_LAST);

`ifdef RAM_RESPONDER_WRITE_EN
  logic [15:0] wdata_hi;
`else
  // Write-side inputs have no function in the read-only build.
  logic unused_write;
  assign unused_write = ^{ram_write, ram_wdata};
  assign sram_dq_out  = '0;
  assign sram_dq_oe   = 1'b0;
  assign sram_we_n    = 1'b1;
`endif

  // Command acceptance, beat sequencing and all registered outputs.
  // Write-path registers sit under the macro so the read-only build drops them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      addr_q         <= '0;
      rd_lo          <= '0;
      ram_cack       <= 1'b0;
      ram_busy       <= 1'b0;
      ram_data_ready <= 1'b0;
      ram_data       <= '0;
      sram_addr      <= '0;
      sram_oe_n      <= 1'b1;
`ifdef RAM_RESPONDER_WRITE_EN
      wdata_hi       <= '0;
      sram_dq_out    <= '0;
      sram_dq_oe     <= 1'b0;
      sram_we_n      <= 1'b1;
`endif
    end else begin
      ram_cack       <= 1'b0;
      ram_data_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (ram_read) begin
            addr_q    <= ram_addr;
            sram_addr <= {ram_addr, 1'b0};
            sram_oe_n <= 1'b0;
            cnt       <= '0;
            ram_cack  <= 1'b1;
            ram_busy  <= 1'b1;
            state     <= RD_LO;
          end
`ifdef RAM_RESPONDER_WRITE_EN
          else if (ram_write) begin
            addr_q      <= ram_addr;
            wdata_hi    <= ram_wdata[31:16];
            sram_addr   <= {ram_addr, 1'b0};
            sram_dq_out <= ram_wdata[15:0];
            sram_dq_oe  <= 1'b1;
            sram_we_n   <= 1'b0;
            cnt         <= '0;
            ram_cack    <= 1'b1;
            ram_busy    <= 1'b1;
            state       <= WR_LO;
          end
`endif
        end
        RD_LO: begin
          if (beat_done) begin
            rd_lo     <= sram_dq_in;
            sram_addr <= {addr_q, 1'b1};
            cnt       <= '0;
            state     <= RD_HI;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RD_HI: begin
          if (beat_done) begin
            ram_data       <= {sram_dq_in, rd_lo};
            ram_data_ready <= 1'b1;
            ram_busy       <= 1'b0;
            sram_oe_n      <= 1'b1;
            state          <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
`ifdef RAM_RESPONDER_WRITE_EN
        WR_LO: begin
          if (beat_done) begin
            sram_we_n <= 1'b1;
            state     <= WR_GAP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_GAP: begin
          sram_addr   <= {addr_q, 1'b1};
          sram_dq_out <= wdata_hi;
          sram_we_n   <= 1'b0;
          cnt         <= '0;
          state       <= WR_HI;
        end
        WR_HI: begin
          if (beat_done) begin
            sram_we_n      <= 1'b1;
            sram_dq_oe     <= 1'b0;
            ram_data_ready <= 1'b1;
            ram_busy       <= 1'b0;
            state          <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder with WAIT_CYCLES=1.
// Write scenarios are built only when RAM_RESPONDER_WRITE_EN is defined.
// Otherwise, the bench checks that writes are ignored.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_read;
  logic        ram_write;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_cack;
  logic        ram_busy;
  logic        ram_data_ready;
  logic [31:0] ram_data;
  logic [16:0] sram_addr;
  logic [15:0] sram_dq_in;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_oe_n;
  logic        sram_we_n;

  int errors = 0;
  int checks = 0;
  logic overlap_seen = 1'b0;

  logic [15:0] mem  [0:255];
  logic [15:0] wmem [0:255];

  ram_responder #(.WAIT_CYCLES(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ram_read       (ram_read),
    .ram_write      (ram_write),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_cack       (ram_cack),
    .ram_busy       (ram_busy),
    .ram_data_ready (ram_data_ready),
    .ram_data       (ram_data),
    .sram_addr      (sram_addr),
    .sram_dq_in     (sram_dq_in),
    .sram_dq_out    (sram_dq_out),
    .sram_dq_oe     (sram_dq_oe),
    .sram_oe_n      (sram_oe_n),
    .sram_we_n      (sram_we_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: reads combinationally, captures writes.
  assign sram_dq_in = mem[sram_addr[7:0]];

  always @(posedge clk) begin
    if (!sram_we_n) wmem[sram_addr[7:0]] <= sram_dq_out;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && sram_oe_n === 1'b0 && sram_we_n === 1'b0) overlap_seen = 1'b1;
  end

  // Waits (bounded) for ram_data_ready; reports cycles waited (-1 on timeout)
  // and how many cack pulses appeared meanwhile.
  task automatic wait_ready(output int cycles, output int cacks);
    bit found;
    found = 0;
    cycles = 0;
    cacks = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      cycles++;
      if (ram_cack) cacks++;
      if (ram_data_ready) found = 1;
    end
    if (!found) cycles = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ram_read = 1'b0; ram_write = 1'b0; ram_addr = '0; ram_wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ram_cack, ram_busy, ram_data_ready, sram_dq_oe, sram_oe_n, sram_we_n} !== 6'b000011) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 000011",
               {ram_cack, ram_busy, ram_data_ready, sram_dq_oe, sram_oe_n, sram_we_n});
    end
    checks++;
    if (ram_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", ram_data); end
    checks++;
    if (sram_addr !== 17'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
    checks++;
    if (sram_dq_out !== 16'h0) begin errors++; $display("FAIL reset_dq: got %h want 0", sram_dq_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    int c, k;
    ram_read = 1'b1; ram_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if ({ram_cack, ram_busy, sram_oe_n, sram_dq_oe} !== 4'b1100) begin
      errors++; $display("FAIL read_accept: cack/busy/oe_n/dq_oe got %b want 1100",
                         {ram_cack, ram_busy, sram_oe_n, sram_dq_oe});
    end
    checks++;
    if (sram_addr !== 17'h00020) begin errors++; $display("FAIL read_lo_addr: got %h want 00020", sram_addr); end
    ram_read = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_cack !== 1'b0) begin errors++; $display("FAIL read_cack_width: got %b want 0", ram_cack); end
    @(negedge clk);
    checks++;
    if ({sram_addr, sram_oe_n} !== {17'h00021, 1'b0}) begin
      errors++; $display("FAIL read_hi_addr: addr %h oe_n %b want 00021/0", sram_addr, sram_oe_n);
    end
    wait_ready(c, k);
    checks++;
    if (c !== 2) begin errors++; $display("FAIL read_latency: got %0d want 4", (c < 0) ? c : c + 2); end
    checks++;
    if (ram_data !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h want deadbeef", ram_data); end
    checks++;
    if ({ram_busy, sram_oe_n} !== 2'b01) begin
      errors++; $display("FAIL read_done_ctl: busy/oe_n got %b want 01", {ram_busy, sram_oe_n});
    end
    @(negedge clk);
    checks++;
    if (ram_data_ready !== 1'b0) begin errors++; $display("FAIL read_ready_width: got %b want 0", ram_data_ready); end
  endtask

  task automatic test_back_to_back();
    int c, k;
    ram_read = 1'b1; ram_addr = 16'h0000;
    @(negedge clk);
    checks++;
    if (ram_cack !== 1'b1) begin errors++; $display("FAIL b2b_cack1: got %b want 1", ram_cack); end
    ram_addr = 16'h0001;
    wait_ready(c, k);
    checks++;
    if (c !== 4 || k !== 0) begin errors++; $display("FAIL b2b_first: latency %0d cacks %0d want 4/0", c, k); end
    checks++;
    if (ram_data !== 32'h22221111) begin errors++; $display("FAIL b2b_data1: got %h want 22221111", ram_data); end
    @(negedge clk);
    checks++;
    if ({ram_cack, sram_addr} !== {1'b1, 17'h00002}) begin
      errors++; $display("FAIL b2b_cack2: cack %b addr %h want 1/00002", ram_cack, sram_addr);
    end
    ram_read = 1'b0;
    wait_ready(c, k);
    checks++;
    if (c !== 4) begin errors++; $display("FAIL b2b_latency2: got %0d want 4", c); end
    checks++;
    if (ram_data !== 32'h44443333) begin errors++; $display("FAIL b2b_data2: got %h want 44443333", ram_data); end
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_data, ram_data_ready} !== {32'h44443333, 1'b0}) begin
      errors++; $display("FAIL data_hold: data %h ready %b want 44443333/0", ram_data, ram_data_ready);
    end
  endtask

  task automatic test_reset_mid();
    int c, k, rdy;
    ram_read = 1'b1; ram_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if (ram_cack !== 1'b1) begin errors++; $display("FAIL rstmid_cack: got %b want 1", ram_cack); end
    repeat (2) @(negedge clk);
    checks++;
    if (sram_addr !== 17'h00021) begin errors++; $display("FAIL rstmid_in_hi: addr %h want 00021", sram_addr); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_cack, ram_busy, ram_data_ready, sram_dq_oe, sram_oe_n, sram_we_n} !== 6'b000011) begin
      errors++; $display("FAIL rstmid_ctl: got %b want 000011",
                         {ram_cack, ram_busy, ram_data_ready, sram_dq_oe, sram_oe_n, sram_we_n});
    end
    checks++;
    if ({ram_data, sram_addr} !== {32'h0, 17'h0}) begin
      errors++; $display("FAIL rstmid_regs: data %h addr %h want 0/0", ram_data, sram_addr);
    end
    rdy = 0;
    repeat (3) begin
      @(negedge clk);
      if (ram_data_ready) rdy++;
    end
    checks++;
    if (rdy !== 0) begin errors++; $display("FAIL rstmid_no_ready: got %0d pulses want 0", rdy); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram_cack, ram_busy, sram_addr} !== {1'b1, 1'b1, 17'h00020}) begin
      errors++; $display("FAIL rstmid_reaccept: cack %b busy %b addr %h want 1/1/00020",
                         ram_cack, ram_busy, sram_addr);
    end
    ram_read = 1'b0;
    wait_ready(c, k);
    checks++;
    if (c !== 4 || ram_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rstmid_read: latency %0d data %h want 4/deadbeef", c, ram_data);
    end
  endtask

  task automatic test_priority();
    int c, k;
    ram_read = 1'b1; ram_write = 1'b1; ram_addr = 16'h0001; ram_wdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if ({ram_cack, sram_oe_n, sram_we_n} !== 3'b101) begin
      errors++; $display("FAIL prio_read_first: cack/oe_n/we_n got %b want 101",
                         {ram_cack, sram_oe_n, sram_we_n});
    end
    ram_read = 1'b0;
    wait_ready(c, k);
    checks++;
    if (c !== 4 || k !== 0 || ram_data !== 32'h44443333) begin
      errors++; $display("FAIL prio_read: latency %0d cacks %0d data %h want 4/0/44443333", c, k, ram_data);
    end
`ifdef RAM_RESPONDER_WRITE_EN
    @(negedge clk);
    checks++;
    if ({ram_cack, sram_we_n, sram_addr} !== {1'b1, 1'b0, 17'h00002}) begin
      errors++; $display("FAIL prio_write_retry: cack %b we_n %b addr %h want 1/0/00002",
                         ram_cack, sram_we_n, sram_addr);
    end
    ram_write = 1'b0;
    wait_ready(c, k);
    checks++;
    if (c !== 5 || ram_data !== 32'h44443333) begin
      errors++; $display("FAIL prio_write_done: latency %0d data %h want 5/44443333", c, ram_data);
    end
    checks++;
    if ({wmem[2], wmem[3]} !== 32'hF00DCAFE) begin
      errors++; $display("FAIL prio_write_mem: got %h %h want f00d cafe", wmem[2], wmem[3]);
    end
`else
    k = 0;
    repeat (5) begin
      @(negedge clk);
      if (ram_cack) k++;
    end
    ram_write = 1'b0;
    checks++;
    if (k !== 0) begin errors++; $display("FAIL prio_write_ignored: got %0d cacks want 0", k); end
`endif
    @(negedge clk);
  endtask

`ifdef RAM_RESPONDER_WRITE_EN
  task automatic test_write();
    logic [2:0]  ctl_exp [6];
    logic [16:0] addr_exp [6];
    logic [15:0] dq_exp [6];
    logic        drive_exp [6];
    // {we_n, dq_oe, data_ready} per cycle starting at the cack cycle.
    ctl_exp   = '{3'b010, 3'b010, 3'b110, 3'b010, 3'b010, 3'b101};
    addr_exp  = '{17'h6, 17'h6, 17'h6, 17'h7, 17'h7, 17'h7};
    dq_exp    = '{16'h5678, 16'h5678, 16'h5678, 16'h1234, 16'h1234, 16'h1234};
    drive_exp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    ram_write = 1'b1; ram_addr = 16'h0003; ram_wdata = 32'h12345678;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) ram_write = 1'b0;
      checks++;
      if ({sram_we_n, sram_dq_oe, ram_data_ready} !== ctl_exp[i]) begin
        errors++; $display("FAIL write_ctl[%0d]: we_n/dq_oe/ready got %b want %b",
                           i, {sram_we_n, sram_dq_oe, ram_data_ready}, ctl_exp[i]);
      end
      if (drive_exp[i]) begin
        checks++;
        if ({sram_addr, sram_dq_out} !== {addr_exp[i], dq_exp[i]}) begin
          errors++; $display("FAIL write_bus[%0d]: addr %h dq %h want %h %h",
                             i, sram_addr, sram_dq_out, addr_exp[i], dq_exp[i]);
        end
      end
    end
    checks++;
    if (ram_data !== 32'h44443333) begin errors++; $display("FAIL write_data_kept: got %h want 44443333", ram_data); end
    checks++;
    if ({wmem[6], wmem[7]} !== 32'h56781234) begin
      errors++; $display("FAIL write_mem: got %h %h want 5678 1234", wmem[6], wmem[7]);
    end
    @(negedge clk);
  endtask
`else
  task automatic test_write_ignored();
    int cacks, bad;
    cacks = 0; bad = 0;
    ram_write = 1'b1; ram_addr = 16'h0005; ram_wdata = 32'hA5A5A5A5;
    repeat (20) begin
      @(negedge clk);
      if (ram_cack) cacks++;
      if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || ram_busy !== 1'b0) bad++;
    end
    ram_write = 1'b0;
    checks++;
    if (cacks !== 0) begin errors++; $display("FAIL nowrite_cack: got %0d want 0", cacks); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL nowrite_bus: %0d cycles with we_n/dq_oe/busy active want 0", bad); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h00] = 16'h1111; mem[8'h01] = 16'h2222;
    mem[8'h02] = 16'h3333; mem[8'h03] = 16'h4444;
    mem[8'h20] = 16'hBEEF; mem[8'h21] = 16'hDEAD;

    test_reset();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_priority();
`ifdef RAM_RESPONDER_WRITE_EN
    test_write();
`else
    test_write_ignored();
`endif
    checks++;
    if (overlap_seen !== 1'b0) begin errors++; $display("FAIL oe_we_overlap: got %b want 0", overlap_seen); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning extra clock cycles per SRAM beat (0..15).
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ram_read  input  1  read command request, held by initiator until ram_cack.
REQ-005 SHALL have port ram_write  input  1  write command request, held by initiator until ram_cack.
REQ-006 SHALL have port ram_addr  input  16  32-bit word address.
REQ-007 SHALL have port ram_wdata  input  32  write data.
REQ-008 SHALL have port ram_cack  output  1  one-cycle command-accepted pulse.
REQ-009 SHALL have port ram_busy  output  1  transaction in progress.
REQ-010 SHALL have port ram_data_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ram_data  output  32  read data, valid while ram_data_ready=1 and held until the next read completes.
REQ-012 SHALL have port sram_addr  output  17  halfword address to external 16-bit SRAM.
REQ-013 SHALL have ports sram_dq_in  input  16; sram_dq_out  output  16; sram_dq_oe  output  1 (1 = drive bus).
REQ-014 SHALL have ports sram_oe_n  output  1 and sram_we_n  output  1, both active-low.

Function
REQ-015 SHALL implement states IDLE, RD_LO, RD_HI, WR_LO, WR_GAP, WR_HI.
REQ-016 In IDLE, on a posedge with ram_read=1, SHALL register ram_addr, assert ram_cack and ram_busy, and enter RD_LO.
REQ-017 In IDLE, on a posedge with ram_write=1 and ram_read=0, SHALL register ram_addr and ram_wdata, assert ram_cack and ram_busy, and enter WR_LO.
REQ-018 Read SHALL have priority when ram_read=1 and ram_write=1: no cack for the write; the initiator retries.
REQ-019 Requests outside IDLE SHALL be ignored with no cack; ram_cack SHALL be high for exactly one cycle per accepted command.
REQ-020 Each beat (RD_LO, RD_HI, WR_LO, WR_HI) SHALL last WAIT_CYCLES+1 cycles, counted by a 4-bit counter cleared on beat entry.
REQ-021 Low beat SHALL use sram_addr={addr,0}; high beat SHALL use {addr,1}.
REQ-022 Halfwords SHALL be little-endian: bits [15:0] = low halfword, [31:16] = high halfword.
REQ-023 During read beats, sram_oe_n SHALL be 0 and sram_dq_oe SHALL be 0.
REQ-024 Read beats SHALL sample sram_dq_in on the last cycle of the beat.
REQ-025 After RD_HI, SHALL load ram_data, pulse ram_data_ready, deassert ram_busy in the same cycle, and return to IDLE.
REQ-026 Read latency SHALL be 2*(WAIT_CYCLES+1) cycles from the ram_cack cycle to the ram_data_ready cycle.
REQ-027 During write beats, sram_we_n SHALL be 0, sram_dq_oe SHALL be 1, and sram_addr/sram_dq_out SHALL be stable for the whole beat.
REQ-028 WR_GAP SHALL be one cycle with sram_we_n=1 and sram_dq_oe=1.
REQ-029 After WR_HI, SHALL pulse ram_data_ready, deassert ram_busy, leave ram_data unchanged, and return to IDLE.
REQ-030 A new command SHALL be accepted on the posedge immediately following the ram_data_ready cycle.
REQ-031 sram_oe_n and sram_we_n SHALL never be 0 simultaneously.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 While rst_n=0: state=IDLE, counter=0, ram_cack=0, ram_busy=0, ram_data_ready=0, ram_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_oe_n=1, sram_we_n=1.
REQ-034 Reset asserted mid-transaction SHALL abort it immediately with no ram_data_ready; the first posedge after release SHALL accept a pending request normally.

Configuration
REQ-035 Macro RAM_RESPONDER_WRITE_EN SHALL gate the write path.
REQ-036 With RAM_RESPONDER_WRITE_EN defined, REQ-017 and REQ-027..029 SHALL apply.
REQ-037 Without RAM_RESPONDER_WRITE_EN, ram_write SHALL be ignored (never cacked), WR states SHALL not exist, and sram_we_n=1 and sram_dq_oe=0 SHALL be constant.

Verification
REQ-038 WAIT_CYCLES=1; read addr 0x0010, SRAM[0x20]=0xBEEF, [0x21]=0xDEAD -> cack one cycle, ram_data_ready 4 cycles later with ram_data=0xDEADBEEF.
REQ-039 Write 0x12345678 to 0x0003 (WRITE_EN) -> we_n low at 0x00006 with dq 0x5678, one gap cycle, then 0x00007 with dq 0x1234, then ram_data_ready; ram_data unchanged.
REQ-040 ram_read=ram_write=1 at addr 0x0001 -> read cacked only; the write is cacked after the read completes.
REQ-041 Back-to-back reads 0x0000 then 0x0001 -> second cack in the cycle after the first ram_data_ready.
REQ-042 rst_n low during RD_HI -> all outputs at reset values, no data_ready; a held ram_read is cacked on the first posedge after release.
REQ-043 WRITE_EN undefined, ram_write=1 for 20 cycles -> no cack, sram_we_n=1 throughout.
